// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Holds the session state encoding, the stream framing constants and the
// byte-order selection used when two stream bytes are joined into a word.
package instruction_memory_loader_pkg;

  // Load session states, in stream order.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_ADDR  = 3'd1,
    ST_HDR_COUNT = 3'd2,
    ST_DATA      = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // Header is START word plus COUNT word; trailer is a single checksum byte.
  localparam int HDR_BYTES   = 4;
  localparam int CHECK_BYTES = 1;

  // First byte of a pair lands in the upper half of the word.
  localparam bit BIG_ENDIAN = 1'b1;

  // Running checksum step: XOR of every data byte.
  function automatic logic [7:0] checksum_step(input logic [7:0] acc,
                                               input logic [7:0] data_byte);
    return acc ^ data_byte;
  endfunction

endpackage

// File: rtl/instruction_memory_loader_byte_pair_assembler.sv
// Joins accepted stream bytes into 16-bit words.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   byte_in       current stream byte
//   byte_take     byte_in is consumed on this rising edge
//   flush         drop any half-assembled word (session state is changing)
//   word_valid    combinational: this edge consumes the second byte of a word
//   word          the completed word, valid together with word_valid
module instruction_memory_loader_byte_pair_assembler
  import instruction_memory_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_take,
  input  logic        flush,
  output logic        word_valid,
  output logic [15:0] word
);

  logic       phase_q, phase_d;  // 1: first byte of the pair already held
  logic [7:0] first_q, first_d;

  // Next-state for the pair phase and the held first byte.
  always_comb begin
    phase_d = phase_q;
    first_d = first_q;
    if (flush) begin
      phase_d = 1'b0;
    end else if (byte_take) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        first_d = byte_in;
      end else begin
        first_d = first_q;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Pair phase and first-byte registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      first_q <= 8'h00;
    end else begin
      phase_q <= phase_d;
      first_q <= first_d;
    end
  end

  // A stalled partial word simply waits in first_q until the second byte comes.
  assign word_valid = byte_take & phase_q;
  assign word       = BIG_ENDIAN ? {first_q, byte_in} : {byte_in, first_q};

endmodule

// File: rtl/instruction_memory_loader.sv
// Boot-link instruction memory loader.
// Consumes START, COUNT, COUNT data words and an XOR checksum byte from a
// byte stream, writes the data words to instruction memory and keeps the
// core in reset until a load verifies.
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   start                  begin a session (only honoured while idle)
//   rx_byte/rx_valid       incoming byte stream, rx_ready accepts
//   mem_we/addr/wdata      registered instruction memory write port
//   cpu_hold               core reset request
//   busy, done, error      session status (done is a one-cycle pulse)
//   words_loaded           data words written in the current session
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            checksum_q, checksum_d;
  logic [15:0]           words_loaded_q, words_loaded_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  byte_take;
  logic                  word_valid;
  logic [15:0]           word;
  logic                  flush;

  assign byte_take = rx_valid & rx_ready_q;
  // Any state change ends the current field, so no half word may leak across.
  assign flush     = (state_d != state_q);

  instruction_memory_loader_byte_pair_assembler u_pair (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_in    (rx_byte),
    .byte_take  (byte_take),
    .flush      (flush),
    .word_valid (word_valid),
    .word       (word)
  );

  // Session FSM, header latches, checksum, write address and status outputs.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    count_d        = count_q;
    checksum_d     = checksum_q;
    words_loaded_d = words_loaded_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    done_d         = 1'b0;
    error_d        = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_HDR_ADDR;
          error_d        = 1'b0;
          words_loaded_d = 16'd0;
          checksum_d     = 8'h00;
          cpu_hold_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR_ADDR: begin
        if (word_valid) begin
          base_d  = ADDR_WIDTH'(word);
          state_d = ST_HDR_COUNT;
        end else begin
          state_d = ST_HDR_ADDR;
        end
      end
      ST_HDR_COUNT: begin
        if (word_valid) begin
          count_d = word;
          if (word == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_HDR_COUNT;
        end
      end
      ST_DATA: begin
        if (byte_take) begin
          checksum_d = checksum_step(checksum_q, rx_byte);
        end else begin
          checksum_d = checksum_q;
        end
        if (word_valid) begin
          mem_we_d       = 1'b1;
          // Truncation to ADDR_WIDTH gives the wrap past the top of memory.
          mem_addr_d     = base_q + ADDR_WIDTH'(words_loaded_q);
          mem_wdata_d    = DATA_WIDTH'(word);
          words_loaded_d = words_loaded_q + 16'd1;
          if (words_loaded_d == count_q) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (byte_take) begin
          if (rx_byte == checksum_q) begin
            state_d = ST_DONE;
          end else begin
            // Failed load: core stays held until a later session verifies.
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready/busy are registered from the next state so they line up with it.
    rx_ready_d = (state_d == ST_HDR_ADDR) || (state_d == ST_HDR_COUNT) ||
                 (state_d == ST_DATA)     || (state_d == ST_CHECK);
    busy_d     = (state_d != ST_IDLE);
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      count_q        <= 16'd0;
      checksum_q     <= 8'h00;
      words_loaded_q <= 16'd0;
      rx_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      count_q        <= count_d;
      checksum_q     <= checksum_d;
      words_loaded_q <= words_loaded_d;
      rx_ready_q     <= rx_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Self-checking bench for instruction_memory_loader.
// Two instances share all inputs: ADDR_WIDTH=20 (suffix _a) and
// ADDR_WIDTH=16 (suffix _b), so address wrap is visible on the narrow one.
module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_byte;
  logic        rx_valid;

  logic        rx_ready_a, mem_we_a, cpu_hold_a, busy_a, done_a, error_a;
  logic [19:0] mem_addr_a;
  logic [15:0] mem_wdata_a, words_loaded_a;
  logic        rx_ready_b, mem_we_b, cpu_hold_b, busy_b, done_b, error_b;
  logic [15:0] mem_addr_b;
  logic [15:0] mem_wdata_b, words_loaded_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_memory_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(20)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_ready(rx_ready_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .cpu_hold(cpu_hold_a),
    .busy(busy_a), .done(done_a), .error(error_a), .words_loaded(words_loaded_a)
  );

  instruction_memory_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_ready(rx_ready_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .cpu_hold(cpu_hold_b),
    .busy(busy_b), .done(done_b), .error(error_b), .words_loaded(words_loaded_b)
  );

  typedef struct {
    logic [15:0] base;
    int          count;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  chk;
    int          gap;
    bit          exp_ok;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [31:0] act_a,
                      input logic [31:0] act_b, input logic [31:0] exp);
    chk({name, "_a"}, act_a, exp);
    chk({name, "_b"}, act_b, exp);
  endtask

  task automatic check_reset_values(input string tag);
    chk2({tag, "_rx_ready"}, rx_ready_a, rx_ready_b, 0);
    chk2({tag, "_mem_we"}, mem_we_a, mem_we_b, 0);
    chk2({tag, "_mem_addr"}, mem_addr_a, mem_addr_b, 0);
    chk2({tag, "_mem_wdata"}, mem_wdata_a, mem_wdata_b, 0);
    chk2({tag, "_cpu_hold"}, cpu_hold_a, cpu_hold_b, 1);
    chk2({tag, "_busy"}, busy_a, busy_b, 0);
    chk2({tag, "_done"}, done_a, done_b, 0);
    chk2({tag, "_error"}, error_a, error_b, 0);
    chk2({tag, "_words_loaded"}, words_loaded_a, words_loaded_b, 0);
  endtask

  // Reference checksum: XOR of every data byte.
  function automatic logic [7:0] ref_xor(input logic [15:0] words[$]);
    logic [7:0] x = 8'h00;
    foreach (words[k]) x = x ^ words[k][15:8] ^ words[k][7:0];
    return x;
  endfunction

  // Runs one session. abort_at >= 0 stops driving once that many bytes went in.
  task automatic run_session(input logic [15:0] base, input logic [15:0] words[$],
                             input logic [7:0] chk_byte, input int gap,
                             input bit exp_ok, input int abort_at);
    logic [7:0]  stream[$];
    logic [15:0] cnt;
    int          i, cyc, nwords, data_end;
    bit          take, exp_we;
    longint      ea, eb;
    cnt = 16'(words.size());
    stream = {base[15:8], base[7:0], cnt[15:8], cnt[7:0]};
    foreach (words[k]) begin
      stream.push_back(words[k][15:8]);
      stream.push_back(words[k][7:0]);
    end
    stream.push_back(chk_byte);
    data_end = 4 + 2 * words.size();

    rx_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk2("start_rx_ready", rx_ready_a, rx_ready_b, 1);
    chk2("start_busy", busy_a, busy_b, 1);
    chk2("start_cpu_hold", cpu_hold_a, cpu_hold_b, 1);
    chk2("start_error", error_a, error_b, 0);
    chk2("start_words", words_loaded_a, words_loaded_b, 0);

    i = 0; cyc = 0; nwords = 0;
    while (i < stream.size() && i != abort_at && cyc < 2000) begin
      rx_valid = ($urandom_range(99) >= gap);
      rx_byte  = rx_valid ? stream[i] : 8'($urandom);
      start    = ($urandom_range(7) == 0);  // must be ignored mid-session
      take     = rx_valid;
      chk2("rx_ready", rx_ready_a, rx_ready_b, 1);
      @(posedge clk); #1;
      exp_we = take && (i >= 4) && (i < data_end) && (((i - 4) % 2) == 1);
      if (take) i++;
      chk2("mem_we", mem_we_a, mem_we_b, exp_we);
      if (exp_we) begin
        ea = (longint'(base) + nwords) % (longint'(1) << 20);
        eb = (longint'(base) + nwords) % (longint'(1) << 16);
        chk("mem_addr_a", mem_addr_a, 32'(ea));
        chk("mem_addr_b", mem_addr_b, 32'(eb));
        chk2("mem_wdata", mem_wdata_a, mem_wdata_b, words[nwords]);
        nwords++;
      end
      chk2("words_loaded", words_loaded_a, words_loaded_b, nwords);
      cyc++;
    end
    rx_valid = 1'b0;
    start = 1'b0;
    if (cyc >= 2000) begin
      checks++; errors++;
      $display("FAIL session_timeout bytes_sent=%0d required=%0d", i, stream.size());
    end
    if (abort_at < 0) begin
      chk2("chk_edge_error", error_a, error_b, !exp_ok);
      chk2("chk_edge_done", done_a, done_b, 0);
      chk2("chk_edge_cpu_hold", cpu_hold_a, cpu_hold_b, 1);
      chk2("chk_edge_rx_ready", rx_ready_a, rx_ready_b, 0);
      @(posedge clk); #1;
      chk2("done_pulse", done_a, done_b, exp_ok);
      chk2("release_cpu_hold", cpu_hold_a, cpu_hold_b, !exp_ok);
      chk2("end_mem_we", mem_we_a, mem_we_b, 0);
      @(posedge clk); #1;
      chk2("done_after", done_a, done_b, 0);
      chk2("end_busy", busy_a, busy_b, 0);
      chk2("end_error", error_a, error_b, !exp_ok);
      chk2("end_cpu_hold", cpu_hold_a, cpu_hold_b, !exp_ok);
      chk2("end_words", words_loaded_a, words_loaded_b, words.size());
    end
  endtask

  initial begin
    logic [15:0] wq[$];
    logic [7:0]  c;
    bit          ok;

    vecs[0] = '{base:16'h0010, count:2, w0:16'h1234, w1:16'hABCD, chk:8'h40, gap:0,  exp_ok:1'b1};
    vecs[1] = '{base:16'h0010, count:2, w0:16'h1234, w1:16'hABCD, chk:8'h41, gap:0,  exp_ok:1'b0};
    vecs[2] = '{base:16'h0005, count:0, w0:16'h0000, w1:16'h0000, chk:8'h00, gap:0,  exp_ok:1'b1};
    vecs[3] = '{base:16'hFFFF, count:2, w0:16'h1234, w1:16'hABCD, chk:8'h40, gap:30, exp_ok:1'b1};

    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;

    // Idle: offered bytes without start must not be taken or written.
    rx_valid = 1'b1; rx_byte = 8'h5A;
    repeat (5) begin
      @(posedge clk); #1;
      chk2("idle_rx_ready", rx_ready_a, rx_ready_b, 0);
      chk2("idle_mem_we", mem_we_a, mem_we_b, 0);
      chk2("idle_cpu_hold", cpu_hold_a, cpu_hold_b, 1);
      chk2("idle_busy", busy_a, busy_b, 0);
    end
    rx_valid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      wq = {};
      if (vecs[v].count > 0) wq.push_back(vecs[v].w0);
      if (vecs[v].count > 1) wq.push_back(vecs[v].w1);
      run_session(vecs[v].base, wq, vecs[v].chk, vecs[v].gap, vecs[v].exp_ok, -1);
    end

    // Reset in the middle of the second data word.
    wq = {16'h1111, 16'h2222, 16'h3333};
    run_session(16'h0200, wq, ref_xor(wq), 40, 1'b1, 7);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    wq = {16'hBEEF, 16'h0001, 16'h8000};
    run_session(16'h0300, wq, ref_xor(wq), 40, 1'b1, -1);

    // Randomized sessions against the model.
    for (int s = 0; s < 12; s++) begin
      wq = {};
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) wq.push_back(16'($urandom));
      c = ref_xor(wq);
      if ($urandom_range(4) == 0) c = c ^ 8'(1 << $urandom_range(7));
      ok = (c == ref_xor(wq));
      run_session(16'($urandom), wq, c, $urandom_range(60), ok, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Write-side counterpart of the fetch path: accepts a byte stream from a host link, assembles 16-bit instruction words and writes them into instruction memory while holding the processor core in reset. On a verified load it releases the core; on a checksum failure it keeps the core held and flags an error. Sits between the external boot link and the instruction memory write port, in front of the processor integration.

## Interface
- DATA_WIDTH, 16, instruction word width (fixed at two bytes)
- ADDR_WIDTH, 20, instruction memory word-address width

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin a load session (ignored unless idle)
- rx_byte  in  8  incoming byte
- rx_valid  in  1  rx_byte valid
- rx_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_WIDTH  word address for write
- mem_wdata  out  DATA_WIDTH  word to write
- cpu_hold  out  1  holds processor in reset while high
- busy  out  1  session in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky checksum failure, cleared by next start
- words_loaded  out  16  data words written this session

## Operation
- Byte transfer occurs on a rising edge with rx_valid && rx_ready; no other byte is consumed.
- Words are big-endian: first byte → bits 15:8, second → 7:0.
- Stream format: START word (base word address), COUNT word, COUNT data words, one CHECKSUM byte.
- Checksum = XOR of all data bytes only (header excluded).
- States: IDLE, HDR_ADDR, HDR_COUNT, DATA, CHECK, DONE.
  - IDLE: rx_ready=0, busy=0. start → HDR_ADDR; clears error, words_loaded, checksum; sets cpu_hold=1.
  - HDR_ADDR: after two bytes, latch base (zero-extended to ADDR_WIDTH) → HDR_COUNT.
  - HDR_COUNT: after two bytes, latch count; count==0 → CHECK, else → DATA.
  - DATA: each completed word issues one write to base+index; after the COUNT-th word → CHECK.
  - CHECK: one byte; match → DONE; mismatch → IDLE with error=1, cpu_hold stays 1.
  - DONE: done=1 one cycle, cpu_hold=0 → IDLE.
- Address arithmetic modulo 2**ADDR_WIDTH (wraps to 0 past top).
- start during any non-IDLE state ignored.
- rx_valid stalls are legal anywhere, including between the two bytes of a word; partial word is held.

## Timing
- Reset values: state IDLE, rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, busy 0, done 0, error 0, words_loaded 0.
- rx_ready is a registered function of state: 1 in HDR_ADDR, HDR_COUNT, DATA, CHECK; first high the cycle after start.
- Write latency: mem_we, mem_addr, mem_wdata registered, valid for exactly one cycle immediately after the edge accepting a word's second byte; words_loaded increments on the same edge.
- Back-to-back words at full byte rate sustained: one write per two accepted bytes, no backpressure.
- done and cpu_hold falling occur on the same edge, one cycle after the checksum byte is accepted.
- Reset asserted mid-session: immediate return to reset values; partially written memory contents are not undone.

## Structure
- Shared package: state enum, HDR_BYTES=4, CHECK_BYTES=1, byte order constant.
- One sub-module: byte_pair_assembler (byte phase toggle, high-byte register, word_valid pulse, flush on state change).
- Top: FSM, counters, checksum, address generator.

## Test plan
- Reset then idle: rx_valid=1 with no start → rx_ready stays 0, cpu_hold=1, no writes.
- start; bytes 00 10 00 02 12 34 AB CD, checksum 12^34^AB^CD=40 → writes 0x1234@0x10, 0xABCD@0x11; done pulse; cpu_hold 0; words_loaded 2.
- Same stream, checksum 0x41 → both writes still issued, no done, error=1, cpu_hold=1; next start clears error.
- COUNT=0: 00 05 00 00 00 → no mem_we, done pulse.
- Base 0xFFFF with ADDR_WIDTH=16, count 2 → writes at 0xFFFF then 0x0000.
- Random rx_valid gaps plus reset_n low after first data word → outputs at reset values immediately; new start loads correctly.
